// File: rtl/ah_demux_pkg.sv
// Shared types and constants for the packet route controller in front of the 16-way demux.
package ah_demux_pkg;

    localparam int SEL_W      = 4;
    localparam int DEF_DATA_W = 85;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUTE = 2'd1,
        DROP  = 2'd2
    } state_t;

endpackage

// File: rtl/ah_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module ah_sat_counter #(
    parameter int             W   = 16,
    parameter logic [W-1:0]   MAX = {W{1'b1}}
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    // Count register: hold at MAX once reached.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != MAX)) begin
            cnt <= cnt + W'(1);
        end else begin
            cnt <= cnt;
        end
    end

endmodule

// File: rtl/ah_demux_route_ctrl.sv
// Packet-level route controller: latches the header destination into demux_select,
// gates beats of the current packet into the demux, sinks bad-dest packets, flags long stalls.
module ah_demux_route_ctrl
    import ah_demux_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int DEST_LSB  = 0,
    parameter int NUM_EGR   = 15,
    parameter int STALL_MAX = 1024,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] ing_data,
    input  logic              ing_valid,
    input  logic              ing_last,
    output logic              ing_ready,
    output logic [DATA_W-1:0] dmx_data,
    output logic              dmx_valid,
    input  logic              dmx_ready,
    output logic [SEL_W-1:0]  demux_select,
    input  logic              err_clr,
    output logic [CNT_W-1:0]  drop_cnt,
    output logic              stall_err,
    output logic              busy
);

    localparam int STALL_W = $clog2(STALL_MAX + 1);

    state_t             state;
    logic [SEL_W-1:0]   dest;
    logic               dest_ok;
    logic               drop_inc;
    logic               stall_inc;
    logic               stall_clr;
    logic               stall_set;
    logic [STALL_W-1:0] stall_cnt;

    assign dest     = ing_data[DEST_LSB +: SEL_W];
    assign dest_ok  = (32'(dest) < 32'(NUM_EGR));
    assign dmx_data = ing_data;

    // Handshake gating decoded from the registered state only, so dmx_valid never sees dmx_ready.
    always_comb begin
        ing_ready = 1'b0;
        dmx_valid = 1'b0;
        case (state)
            IDLE: begin
                ing_ready = 1'b0;
                dmx_valid = 1'b0;
            end
            ROUTE: begin
                ing_ready = dmx_ready;
                dmx_valid = ing_valid;
            end
            DROP: begin
                ing_ready = 1'b1;
                dmx_valid = 1'b0;
            end
            default: begin
                ing_ready = 1'b0;
                dmx_valid = 1'b0;
            end
        endcase
    end

    // Packet FSM; demux_select is only written on the IDLE to ROUTE transition.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            demux_select <= '0;
            busy         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ing_valid && dest_ok) begin
                        state        <= ROUTE;
                        demux_select <= dest;
                        busy         <= 1'b1;
                    end else if (ing_valid) begin
                        state <= DROP;
                        busy  <= 1'b1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                ROUTE: begin
                    if (ing_valid && dmx_ready && ing_last) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state <= ROUTE;
                        busy  <= 1'b1;
                    end
                end
                DROP: begin
                    if (ing_valid && ing_last) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state <= DROP;
                        busy  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign drop_inc  = (state == IDLE) && ing_valid && !dest_ok;
    assign stall_inc = (state == ROUTE) && ing_valid && !dmx_ready;
    assign stall_clr = (state != ROUTE) || (ing_valid && dmx_ready);
    // Flag on the same edge the stall count lands on STALL_MAX, and keep re-asserting while saturated.
    assign stall_set = stall_inc && (32'(stall_cnt) >= 32'(STALL_MAX - 1));

    ah_sat_counter #(
        .W   (CNT_W),
        .MAX ({CNT_W{1'b1}})
    ) u_drop_cnt (
        .clk (clk),
        .rst (rst),
        .inc (drop_inc),
        .clr (1'b0),
        .cnt (drop_cnt)
    );

    ah_sat_counter #(
        .W   (STALL_W),
        .MAX (STALL_W'(STALL_MAX))
    ) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (stall_inc),
        .clr (stall_clr),
        .cnt (stall_cnt)
    );

    // Sticky stall error; a set in the same cycle as err_clr wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_err <= 1'b0;
        end else if (stall_set) begin
            stall_err <= 1'b1;
        end else if (err_clr) begin
            stall_err <= 1'b0;
        end else begin
            stall_err <= stall_err;
        end
    end

endmodule

// File: tb/tb_ah_demux_route_ctrl.sv
// Bench for ah_demux_route_ctrl: directed and randomized packets checked against a packet-level model.
module tb_ah_demux_route_ctrl;

    localparam int DW   = 85;
    localparam int SMAX = 8;
    localparam int CW   = 8;
    localparam int DMAX = 255;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] ing_data;
    logic          ing_valid;
    logic          ing_last;
    logic          ing_ready;
    logic [DW-1:0] dmx_data;
    logic          dmx_valid;
    logic          dmx_ready;
    logic [3:0]    demux_select;
    logic          err_clr;
    logic [CW-1:0] drop_cnt;
    logic          stall_err;
    logic          busy;

    ah_demux_route_ctrl #(
        .DATA_W    (DW),
        .DEST_LSB  (0),
        .NUM_EGR   (15),
        .STALL_MAX (SMAX),
        .CNT_W     (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ing_data     (ing_data),
        .ing_valid    (ing_valid),
        .ing_last     (ing_last),
        .ing_ready    (ing_ready),
        .dmx_data     (dmx_data),
        .dmx_valid    (dmx_valid),
        .dmx_ready    (dmx_ready),
        .demux_select (demux_select),
        .err_clr      (err_clr),
        .drop_cnt     (drop_cnt),
        .stall_err    (stall_err),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Packet-level reference: waiting for a header, or inside a routed / sunk packet.
    bit m_wait_hdr;
    bit m_sinking;
    int m_sel;
    int m_drops;
    int m_stall;
    bit m_err;
    bit m_acc;
    int hs_cnt = 0;
    int cyc = 0;
    bit alt = 1'b1;

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic mreset();
        m_wait_hdr = 1'b1;
        m_sinking  = 1'b0;
        m_sel      = 0;
        m_drops    = 0;
        m_stall    = 0;
        m_err      = 1'b0;
    endtask

    task automatic cycle();
        logic er;
        logic ev;
        bit   set;
        int   d;
        @(negedge clk);
        er = m_wait_hdr ? 1'b0 : (m_sinking ? 1'b1 : dmx_ready);
        ev = !m_wait_hdr && !m_sinking && ing_valid;
        chk("ing_ready", 96'(ing_ready), 96'(er));
        chk("dmx_valid", 96'(dmx_valid), 96'(ev));
        chk("demux_select", 96'(demux_select), 96'(m_sel));
        chk("drop_cnt", 96'(drop_cnt), 96'(m_drops));
        chk("stall_err", 96'(stall_err), 96'(m_err));
        chk("busy", 96'(busy), 96'(!m_wait_hdr));
        if (ev) chk("dmx_data", 96'(dmx_data), 96'(ing_data));
        @(posedge clk);
        cyc++;
        set   = 1'b0;
        m_acc = ing_valid && er;
        if (ev && dmx_ready) hs_cnt++;
        if (m_wait_hdr) begin
            if (ing_valid) begin
                d = int'(ing_data[3:0]);
                m_wait_hdr = 1'b0;
                if (d < 15) begin
                    m_sel     = d;
                    m_sinking = 1'b0;
                end else begin
                    m_sinking = 1'b1;
                    m_drops   = (m_drops < DMAX) ? m_drops + 1 : DMAX;
                end
            end
        end else if (m_sinking) begin
            if (ing_valid && ing_last) m_wait_hdr = 1'b1;
        end else if (ing_valid && !dmx_ready) begin
            if (m_stall < SMAX) m_stall++;
            if (m_stall == SMAX) set = 1'b1;
        end else if (ing_valid) begin
            m_stall = 0;
            if (ing_last) m_wait_hdr = 1'b1;
        end
        if (set) m_err = 1'b1;
        else if (err_clr) m_err = 1'b0;
        #1;
    endtask

    function automatic logic [DW-1:0] rnd_data();
        logic [95:0] r;
        r = {$urandom(), $urandom(), $urandom()};
        return r[DW-1:0];
    endfunction

    // mode 0: ready held high, 1: alternating, 2: random. gap inserts idle ingress cycles.
    task automatic send_pkt(input int dest, input int nb, input int mode, input bit gap);
        logic [DW-1:0] data;
        bit            done;
        int            guard;
        for (int b = 0; b < nb; b++) begin
            data = rnd_data();
            if (b == 0) data[3:0] = 4'(dest);
            done  = 1'b0;
            guard = 0;
            while (!done && guard < 100) begin
                ing_data  = data;
                ing_last  = (b == nb - 1);
                ing_valid = gap ? ($urandom_range(0, 3) != 0) : 1'b1;
                case (mode)
                    0:       dmx_ready = 1'b1;
                    1:       begin dmx_ready = alt; alt = !alt; end
                    default: dmx_ready = 1'($urandom_range(0, 1));
                endcase
                cycle();
                done = m_acc;
                guard++;
            end
            if (!done) begin
                n_cmp++;
                n_bad++;
                $error("FAIL beat_timeout beat=%0d observed=not_accepted expected=accepted", b);
            end
        end
        ing_valid = 1'b0;
        ing_last  = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int h0;
        int c0;
        rst       = 1'b1;
        ing_data  = '0;
        ing_valid = 1'b0;
        ing_last  = 1'b0;
        dmx_ready = 1'b0;
        err_clr   = 1'b0;
        mreset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 96'(busy), 96'(0));
        chk("rst_sel", 96'(demux_select), 96'(0));
        chk("rst_drop", 96'(drop_cnt), 96'(0));
        chk("rst_err", 96'(stall_err), 96'(0));
        rst = 1'b0;

        // 4-beat packet to egress 3, 1-cycle header bubble
        h0 = hs_cnt; c0 = cyc;
        send_pkt(3, 4, 0, 1'b0);
        chk("p3_handshakes", 96'(hs_cnt - h0), 96'(4));
        chk("p3_cycles", 96'(cyc - c0), 96'(5));
        chk("p3_sel", 96'(demux_select), 96'(3));

        // back-to-back single-beat packets take 2 cycles each
        c0 = cyc;
        send_pkt(0, 1, 0, 1'b0);
        chk("p0_cycles", 96'(cyc - c0), 96'(2));
        c0 = cyc;
        send_pkt(14, 1, 0, 1'b0);
        chk("p14_cycles", 96'(cyc - c0), 96'(2));
        chk("p14_sel", 96'(demux_select), 96'(14));

        // nonexistent egress 15: sunk, counted, select untouched
        h0 = hs_cnt;
        send_pkt(15, 3, 2, 1'b0);
        chk("drop_first", 96'(drop_cnt), 96'(1));
        chk("drop_sel_kept", 96'(demux_select), 96'(14));
        chk("drop_no_hs", 96'(hs_cnt - h0), 96'(0));
        for (int i = 0; i < DMAX - 1; i++) send_pkt(15, 1, 0, 1'b0);
        chk("drop_full", 96'(drop_cnt), 96'(DMAX));
        send_pkt(15, 1, 0, 1'b0);
        chk("drop_sat", 96'(drop_cnt), 96'(DMAX));

        // stall error after SMAX stalled cycles; coincident err_clr loses
        ing_data      = rnd_data();
        ing_data[3:0] = 4'd5;
        ing_valid     = 1'b1;
        ing_last      = 1'b1;
        dmx_ready     = 1'b0;
        cycle();
        for (int i = 0; i < SMAX - 1; i++) cycle();
        chk("stall_pre", 96'(stall_err), 96'(0));
        cycle();
        chk("stall_set", 96'(stall_err), 96'(1));
        err_clr = 1'b1;
        cycle();
        chk("stall_clr_vs_set", 96'(stall_err), 96'(1));
        err_clr   = 1'b0;
        dmx_ready = 1'b1;
        cycle();
        chk("stall_pkt_done", 96'(busy), 96'(0));
        ing_valid = 1'b0;
        ing_last  = 1'b0;
        err_clr   = 1'b1;
        cycle();
        chk("stall_cleared", 96'(stall_err), 96'(0));
        err_clr = 1'b0;

        // alternating backpressure never accumulates a stall
        h0 = hs_cnt;
        send_pkt(9, 6, 1, 1'b0);
        chk("alt_handshakes", 96'(hs_cnt - h0), 96'(6));
        chk("alt_no_err", 96'(stall_err), 96'(0));

        // randomized packets with ingress gaps and random backpressure
        for (int i = 0; i < 30; i++) begin
            send_pkt(int'($urandom_range(0, 15)), int'($urandom_range(1, 5)), int'($urandom_range(0, 2)), 1'b1);
        end

        // asynchronous reset in the middle of a 5-beat packet to egress 7
        ing_data      = rnd_data();
        ing_data[3:0] = 4'd7;
        ing_valid     = 1'b1;
        ing_last      = 1'b0;
        dmx_ready     = 1'b1;
        cycle();
        cycle();
        ing_data = rnd_data();
        cycle();
        chk("pre_rst_sel", 96'(demux_select), 96'(7));
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_busy", 96'(busy), 96'(0));
        chk("arst_sel", 96'(demux_select), 96'(0));
        chk("arst_drop", 96'(drop_cnt), 96'(0));
        chk("arst_err", 96'(stall_err), 96'(0));
        chk("arst_ready", 96'(ing_ready), 96'(0));
        chk("arst_valid", 96'(dmx_valid), 96'(0));
        ing_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        mreset();
        h0 = hs_cnt;
        send_pkt(2, 2, 0, 1'b0);
        chk("post_rst_sel", 96'(demux_select), 96'(2));
        chk("post_rst_hs", 96'(hs_cnt - h0), 96'(2));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
